// File: rtl/pipelined_control_unit_if.sv
// rtl/pipelined_control_unit_if.sv - ID-stage inputs and per-stage control outputs of the control unit
interface pipelined_control_unit_if #(
  parameter int REG_ADDR_W = 5,
  parameter int ALU_OP_W   = 2,
  parameter int CNT_W      = 8
);
  logic                  en;
  logic [6:0]            id_opcode;
  logic [REG_ADDR_W-1:0] id_rs1;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic [REG_ADDR_W-1:0] id_rd;
  logic                  flush_ex;

  logic                  stall;
  logic [ALU_OP_W-1:0]   ex_alu_op;
  logic                  ex_alu_src;
  logic                  ex_branch;
  logic                  ex_jump;
  logic                  mem_read;
  logic                  mem_write;
  logic                  wb_mem_2_reg;
  logic                  wb_reg_write;
  logic [REG_ADDR_W-1:0] ex_rd;
  logic [REG_ADDR_W-1:0] mem_rd;
  logic [REG_ADDR_W-1:0] wb_rd;
  logic [CNT_W-1:0]      illegal_cnt;

  modport master (
    output en, id_opcode, id_rs1, id_rs2, id_rd, flush_ex,
    input  stall, ex_alu_op, ex_alu_src, ex_branch, ex_jump, mem_read, mem_write,
           wb_mem_2_reg, wb_reg_write, ex_rd, mem_rd, wb_rd, illegal_cnt
  );

  modport slave (
    input  en, id_opcode, id_rs1, id_rs2, id_rd, flush_ex,
    output stall, ex_alu_op, ex_alu_src, ex_branch, ex_jump, mem_read, mem_write,
           wb_mem_2_reg, wb_reg_write, ex_rd, mem_rd, wb_rd, illegal_cnt
  );
endinterface

// File: rtl/pipelined_control_unit.sv
// rtl/pipelined_control_unit.sv - ID decode, load-use hazard detection and EX/MEM/WB control pipeline
module pipelined_control_unit #(
  parameter int REG_ADDR_W = 5,
  parameter int ALU_OP_W   = 2,
  parameter int CNT_W      = 8,
  parameter bit EN_EXT     = 1'b1
) (
  input logic                      clk,
  input logic                      rst,
  pipelined_control_unit_if.slave  bus
);
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  localparam logic [ALU_OP_W-1:0] ALU_ADD = ALU_OP_W'(0);
  localparam logic [ALU_OP_W-1:0] ALU_SUB = ALU_OP_W'(1);
  localparam logic [ALU_OP_W-1:0] ALU_R   = ALU_OP_W'(2);

  typedef struct packed {
    logic                  alu_src;
    logic                  mem_2_reg;
    logic                  reg_write;
    logic                  mem_read;
    logic                  mem_write;
    logic                  branch;
    logic                  jump;
    logic [ALU_OP_W-1:0]   alu_op;
    logic [REG_ADDR_W-1:0] rd;
  } ex_ctrl_t;

  typedef struct packed {
    logic                  mem_2_reg;
    logic                  reg_write;
    logic                  mem_read;
    logic                  mem_write;
    logic [REG_ADDR_W-1:0] rd;
  } mem_ctrl_t;

  typedef struct packed {
    logic                  mem_2_reg;
    logic                  reg_write;
    logic [REG_ADDR_W-1:0] rd;
  } wb_ctrl_t;

  ex_ctrl_t   dec;
  logic       uses_rs1, uses_rs2, illegal, hazard;
  ex_ctrl_t   idex_d, idex_q;
  mem_ctrl_t  exmem_d, exmem_q;
  wb_ctrl_t   memwb_d, memwb_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;

  // Illegal opcodes decode to the bubble word and read no sources.
  always_comb begin
    dec      = '0;
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    illegal  = 1'b0;
    case (bus.id_opcode)
      OP_R: begin
        dec.reg_write = 1'b1; dec.alu_op = ALU_R;
        uses_rs1 = 1'b1; uses_rs2 = 1'b1;
      end
      OP_I: begin
        dec.alu_src = 1'b1; dec.reg_write = 1'b1; dec.alu_op = ALU_ADD;
        uses_rs1 = 1'b1;
      end
      OP_LOAD: begin
        dec.alu_src = 1'b1; dec.mem_2_reg = 1'b1; dec.reg_write = 1'b1;
        dec.mem_read = 1'b1; dec.alu_op = ALU_ADD;
        uses_rs1 = 1'b1;
      end
      OP_STORE: begin
        dec.alu_src = 1'b1; dec.mem_write = 1'b1; dec.alu_op = ALU_ADD;
        uses_rs1 = 1'b1; uses_rs2 = 1'b1;
      end
      OP_BEQ: begin
        dec.branch = 1'b1; dec.alu_op = ALU_SUB;
        uses_rs1 = 1'b1; uses_rs2 = 1'b1;
      end
      OP_JAL: begin
        dec.reg_write = 1'b1; dec.jump = 1'b1; dec.alu_op = ALU_ADD;
      end
      OP_JALR: begin
        if (EN_EXT) begin
          dec.alu_src = 1'b1; dec.reg_write = 1'b1; dec.jump = 1'b1; dec.alu_op = ALU_ADD;
          uses_rs1 = 1'b1;
        end else begin
          illegal = 1'b1;
        end
      end
      OP_LUI: begin
        if (EN_EXT) begin
          dec.alu_src = 1'b1; dec.reg_write = 1'b1; dec.alu_op = ALU_ADD;
        end else begin
          illegal = 1'b1;
        end
      end
      default: illegal = 1'b1;
    endcase
    if (!illegal) dec.rd = bus.id_rd;
  end

  assign hazard = idex_q.mem_read && (idex_q.rd != '0) &&
                  ((uses_rs1 && idex_q.rd == bus.id_rs1) || (uses_rs2 && idex_q.rd == bus.id_rs2));
  assign bus.stall = hazard && !bus.flush_ex;

  always_comb begin
    idex_d  = (bus.flush_ex || hazard) ? '0 : dec;
    exmem_d = '{mem_2_reg: idex_q.mem_2_reg, reg_write: idex_q.reg_write,
                mem_read: idex_q.mem_read, mem_write: idex_q.mem_write, rd: idex_q.rd};
    memwb_d = '{mem_2_reg: exmem_q.mem_2_reg, reg_write: exmem_q.reg_write, rd: exmem_q.rd};
    cnt_d   = cnt_q;
    if (illegal && !bus.flush_ex && !hazard && cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idex_q  <= '0;
      exmem_q <= '0;
      memwb_q <= '0;
      cnt_q   <= '0;
    end else if (bus.en) begin
      idex_q  <= idex_d;
      exmem_q <= exmem_d;
      memwb_q <= memwb_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.ex_alu_op    = idex_q.alu_op;
  assign bus.ex_alu_src   = idex_q.alu_src;
  assign bus.ex_branch    = idex_q.branch;
  assign bus.ex_jump      = idex_q.jump;
  assign bus.ex_rd        = idex_q.rd;
  assign bus.mem_read     = exmem_q.mem_read;
  assign bus.mem_write    = exmem_q.mem_write;
  assign bus.mem_rd       = exmem_q.rd;
  assign bus.wb_mem_2_reg = memwb_q.mem_2_reg;
  assign bus.wb_reg_write = memwb_q.reg_write;
  assign bus.wb_rd        = memwb_q.rd;
  assign bus.illegal_cnt  = cnt_q;
endmodule

// File: tb/tb_pipelined_control_unit.sv
// tb/tb_pipelined_control_unit.sv - scoreboard bench for two control units (extensions on and off)
module tb_pipelined_control_unit;
  localparam int RW = 5;
  localparam int AW = 2;
  localparam int CW = 8;

  typedef struct packed {
    logic alu_src, mem_2_reg, reg_write, mem_read, mem_write, branch, jump;
    logic [1:0] alu_op;
    logic [4:0] rd;
  } word_t;

  typedef struct packed {
    bit              chk;
    logic [1:0]      stall;
    logic [1:0][9:0] ex;
    logic [1:0][6:0] mem;
    logic [1:0][6:0] wb;
    logic [1:0][7:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst, en, flush;
  logic [6:0] op;
  logic [4:0] rs1, rs2, rd;
  always #5 clk = ~clk;

  pipelined_control_unit_if #(.REG_ADDR_W(RW), .ALU_OP_W(AW), .CNT_W(CW)) bus1 ();
  pipelined_control_unit_if #(.REG_ADDR_W(RW), .ALU_OP_W(AW), .CNT_W(CW)) bus0 ();

  pipelined_control_unit #(.REG_ADDR_W(RW), .ALU_OP_W(AW), .CNT_W(CW), .EN_EXT(1'b1))
    dut1 (.clk(clk), .rst(rst), .bus(bus1));
  pipelined_control_unit #(.REG_ADDR_W(RW), .ALU_OP_W(AW), .CNT_W(CW), .EN_EXT(1'b0))
    dut0 (.clk(clk), .rst(rst), .bus(bus0));

  assign bus1.en = en;  assign bus1.id_opcode = op;  assign bus1.flush_ex = flush;
  assign bus1.id_rs1 = rs1; assign bus1.id_rs2 = rs2; assign bus1.id_rd = rd;
  assign bus0.en = en;  assign bus0.id_opcode = op;  assign bus0.flush_ex = flush;
  assign bus0.id_rs1 = rs1; assign bus0.id_rs2 = rs2; assign bus0.id_rd = rd;

  int n_cmp = 0;
  int n_bad = 0;
  exp_t exp_q[$];

  // Reference state: stage 0 = EX, 1 = MEM, 2 = WB
  word_t mp[2][3];
  int    mcnt[2];
  bit    last_stall[2];

  logic [6:0] ops[9] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                         7'b1101111, 7'b1100111, 7'b0110111, 7'b1111111};

  function automatic void ref_decode(input bit ext, input logic [6:0] o, input logic [4:0] d,
                                     output word_t w, output bit u1, output bit u2, output bit ill);
    logic [8:0] f;
    ill = 1'b0;
    // alu_src mem_2_reg reg_write mem_read mem_write branch jump alu_op
    case (o)
      7'b0110011: begin f = 9'b0010000_10; u1 = 1; u2 = 1; end
      7'b0010011: begin f = 9'b1010000_00; u1 = 1; u2 = 0; end
      7'b0000011: begin f = 9'b1111000_00; u1 = 1; u2 = 0; end
      7'b0100011: begin f = 9'b1000100_00; u1 = 1; u2 = 1; end
      7'b1100011: begin f = 9'b0000010_01; u1 = 1; u2 = 1; end
      7'b1101111: begin f = 9'b0010001_00; u1 = 0; u2 = 0; end
      7'b1100111: begin f = 9'b1010001_00; u1 = 1; u2 = 0; ill = !ext; end
      7'b0110111: begin f = 9'b1010000_00; u1 = 0; u2 = 0; ill = !ext; end
      default:    begin f = '0; u1 = 0; u2 = 0; ill = 1; end
    endcase
    if (ill) begin f = '0; u1 = 0; u2 = 0; end
    w = {f, ill ? 5'd0 : d};
  endfunction

  task automatic issue(input bit r, input bit e, input logic [6:0] o, input logic [4:0] a,
                       input logic [4:0] b, input logic [4:0] d, input bit f, input bit chk);
    exp_t  x;
    word_t w;
    bit    u1, u2, ill, hz;
    @(negedge clk);
    rst = r; en = e; op = o; rs1 = a; rs2 = b; rd = d; flush = f;
    x = '0;
    x.chk = chk;
    for (int k = 0; k < 2; k++) begin
      ref_decode(k == 1, o, d, w, u1, u2, ill);
      hz = mp[k][0].mem_read && mp[k][0].rd != 0 &&
           ((u1 && mp[k][0].rd == a) || (u2 && mp[k][0].rd == b));
      x.stall[k] = hz && !f;
      last_stall[k] = x.stall[k];
      if (r) begin
        for (int s = 0; s < 3; s++) mp[k][s] = '0;
        mcnt[k] = 0;
      end else if (e) begin
        mp[k][2] = mp[k][1];
        mp[k][1] = mp[k][0];
        mp[k][0] = (f || hz) ? word_t'(0) : w;
        if (ill && !f && !hz && mcnt[k] < 255) mcnt[k]++;
      end
      x.ex[k]  = {mp[k][0].alu_src, mp[k][0].branch, mp[k][0].jump, mp[k][0].alu_op, mp[k][0].rd};
      x.mem[k] = {mp[k][1].mem_read, mp[k][1].mem_write, mp[k][1].rd};
      x.wb[k]  = {mp[k][2].mem_2_reg, mp[k][2].reg_write, mp[k][2].rd};
      x.cnt[k] = mcnt[k][7:0];
    end
    exp_q.push_back(x);
  endtask

  task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s (ext=%0d) at %0t: got %h expected %h", name, k, $time, act, exp);
    end
  endtask

  task automatic nop(input int n);
    for (int i = 0; i < n; i++) issue(0, 1, 7'b0010011, 0, 0, 0, 0, 1);
  endtask

  // Monitor: stall sampled just before the edge, stage outputs just after
  initial begin
    exp_t x;
    logic s1, s0;
    forever begin
      @(negedge clk);
      #3;
      s1 = bus1.stall;
      s0 = bus0.stall;
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        x = exp_q.pop_front();
        if (x.chk) begin
          check("stall", 1, 32'(s1), 32'(x.stall[1]));
          check("stall", 0, 32'(s0), 32'(x.stall[0]));
        end
        check("ex",  1, 32'({bus1.ex_alu_src, bus1.ex_branch, bus1.ex_jump, bus1.ex_alu_op, bus1.ex_rd}), 32'(x.ex[1]));
        check("ex",  0, 32'({bus0.ex_alu_src, bus0.ex_branch, bus0.ex_jump, bus0.ex_alu_op, bus0.ex_rd}), 32'(x.ex[0]));
        check("mem", 1, 32'({bus1.mem_read, bus1.mem_write, bus1.mem_rd}), 32'(x.mem[1]));
        check("mem", 0, 32'({bus0.mem_read, bus0.mem_write, bus0.mem_rd}), 32'(x.mem[0]));
        check("wb",  1, 32'({bus1.wb_mem_2_reg, bus1.wb_reg_write, bus1.wb_rd}), 32'(x.wb[1]));
        check("wb",  0, 32'({bus0.wb_mem_2_reg, bus0.wb_reg_write, bus0.wb_rd}), 32'(x.wb[0]));
        check("illegal_cnt", 1, 32'(bus1.illegal_cnt), 32'(x.cnt[1]));
        check("illegal_cnt", 0, 32'(bus0.illegal_cnt), 32'(x.cnt[0]));
      end
    end
  end

  initial begin
    logic [6:0] o;
    logic [4:0] a, b, d;
    rst = 1; en = 0; flush = 0; op = '0; rs1 = '0; rs2 = '0; rd = '0;
    for (int k = 0; k < 2; k++) begin
      for (int s = 0; s < 3; s++) mp[k][s] = '0;
      mcnt[k] = 0;
      last_stall[k] = 0;
    end

    issue(1, 1'($urandom), 7'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 1'($urandom), 0);
    issue(1, 1'($urandom), 7'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 1'($urandom), 1);

    issue(0, 1, 7'b0110011, 1, 2, 5, 0, 1);
    nop(3);
    issue(0, 1, 7'b0000011, 1, 0, 5, 0, 1);
    issue(0, 1, 7'b0110011, 5, 2, 6, 0, 1);
    issue(0, 1, 7'b0110011, 5, 2, 6, 0, 1);
    nop(2);
    issue(0, 1, 7'b0000011, 1, 0, 0, 0, 1);
    issue(0, 1, 7'b0110011, 0, 0, 3, 0, 1);
    nop(2);
    issue(0, 1, 7'b0000011, 1, 0, 7, 0, 1);
    issue(0, 1, 7'b0110011, 1, 7, 4, 1, 1);
    issue(0, 1, 7'b0110011, 1, 7, 4, 0, 1);
    issue(0, 1, 7'b1111111, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++)
      issue(0, 0, ops[$urandom_range(0, 8)], 5'($urandom), 5'($urandom), 5'($urandom), 0, 1);
    nop(3);
    for (int i = 0; i < 300; i++) issue(0, 1, 7'b1111111, 0, 0, 0, 0, 1);
    issue(0, 1, 7'b1100111, 1, 0, 4, 0, 1);
    nop(3);
    issue(1, 1, 7'b0110011, 0, 0, 1, 0, 1);

    o = ops[0]; a = 0; b = 0; d = 0;
    for (int i = 0; i < 2000; i++) begin
      if (!last_stall[1]) begin
        o = ($urandom_range(0, 9) == 0) ? 7'($urandom) : ops[$urandom_range(0, 8)];
        a = 5'($urandom_range(0, 3));
        b = 5'($urandom_range(0, 3));
        d = 5'($urandom_range(0, 3));
      end
      issue($urandom_range(0, 199) == 0, $urandom_range(0, 9) != 0, o, a, b, d,
            $urandom_range(0, 7) == 0, 1);
    end

    @(posedge clk);
    #3;
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
